sync_fifo_ctrl: RTL and testbench

//  Single-clock FIFO wrapped around the team's dual-port RAM (ram_top).

---
 rtl/fifo_pkg.sv | 24 ++
 rtl/ram_top.sv | 46 ++++
 rtl/sync_fifo_ctrl.sv | 133 +++++++++++++
 tb/tb_sync_fifo_ctrl.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// ============================================================================
// fifo_pkg : shared defaults and helpers for the synchronous FIFO controller
// Rev 1.0
// ============================================================================
`default_nettype none

package fifo_pkg;

   localparam int FIFO_DEPTH_DEF = 16;
   localparam int FIFO_WIDTH_DEF = 32;

   // Ceiling log2, usable in parameter defaults; returns 0 for values <= 1.
   function automatic int clog2(input int value);
      int result;
      result = 0;
      for (int v = value - 1; v > 0; v = v >> 1) begin
         result = result + 1;
      end
      return result;
   endfunction

endpackage

`default_nettype wire

// File: rtl/ram_top.sv
// ============================================================================
// ram_top : simple dual-port RAM, one write port, one registered read port
// Rev 1.0
// ============================================================================
`default_nettype none

module ram_top
   import fifo_pkg::*;
#(
   parameter int DEPTH = FIFO_DEPTH_DEF,
   parameter int WIDTH = FIFO_WIDTH_DEF,
   parameter int AW    = clog2(DEPTH)
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             wr_i,
   input  logic [AW-1:0]    waddr_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic             rd_i,
   input  logic [AW-1:0]    raddr_i,
   output logic [WIDTH-1:0] rdata_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] rdata_q;

   always_ff @(posedge clk_i) begin
      if (wr_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   // Only the output register is reset; array contents are don't-care until written.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rdata_q <= '0;
      end else if (rd_i) begin
         rdata_q <= mem_q[raddr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

`default_nettype wire

// File: rtl/sync_fifo_ctrl.sv
// ============================================================================
// sync_fifo_ctrl : single-clock FIFO controller around ram_top with
//                  occupancy flags and sticky overflow/underflow
// Rev 1.0
// ============================================================================
`default_nettype none

module sync_fifo_ctrl
   import fifo_pkg::*;
#(
   parameter int DEPTH  = FIFO_DEPTH_DEF,
   parameter int WIDTH  = FIFO_WIDTH_DEF,
   parameter int ADDR_W = clog2(DEPTH),
   parameter int AFULL  = DEPTH - 2
) (
   input  logic              i_sys_clk,
   input  logic              i_rst_n,
   input  logic              i_clr,
   input  logic              i_push,
   input  logic [WIDTH-1:0]  i_push_data,
   input  logic              i_pop,
   output logic [WIDTH-1:0]  o_rd_data,
   output logic              o_rd_valid,
   output logic              o_full,
   output logic              o_empty,
   output logic              o_afull,
   output logic [ADDR_W:0]   o_count,
   output logic              o_ovf,
   output logic              o_udf
);

   localparam int             RAM_AW  = clog2(DEPTH);
   localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0] AFULL_C = (ADDR_W+1)'(AFULL);

   logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [ADDR_W:0]   count_q,  count_d;
   logic              ovf_q,    ovf_d;
   logic              udf_q,    udf_d;
   logic              rd_valid_q, rd_valid_d;

   logic              full;
   logic              empty;
   logic              push_ok;
   logic              pop_ok;

   assign full    = (count_q == DEPTH_C);
   assign empty   = (count_q == '0);

   // A flush wins over any request in the same cycle.
   assign push_ok = i_push & ~full  & ~i_clr;
   assign pop_ok  = i_pop  & ~empty & ~i_clr;

   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      ovf_d      = ovf_q;
      udf_d      = udf_q;
      rd_valid_d = pop_ok;

      if (i_clr) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
         ovf_d    = 1'b0;
         udf_d    = 1'b0;
      end else begin
         if (push_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
         end
         if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
         end
         if (push_ok && !pop_ok) begin
            count_d = count_q + 1'b1;
         end else if (pop_ok && !push_ok) begin
            count_d = count_q - 1'b1;
         end
         if (i_push && full) begin
            ovf_d = 1'b1;
         end
         if (i_pop && empty) begin
            udf_d = 1'b1;
         end
      end
   end

   always_ff @(posedge i_sys_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         ovf_q      <= 1'b0;
         udf_q      <= 1'b0;
         rd_valid_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         ovf_q      <= ovf_d;
         udf_q      <= udf_d;
         rd_valid_q <= rd_valid_d;
      end
   end

   ram_top #(
      .DEPTH (DEPTH),
      .WIDTH (WIDTH),
      .AW    (RAM_AW)
   ) u_ram (
      .clk_i   (i_sys_clk),
      .rst_ni  (i_rst_n),
      .wr_i    (push_ok),
      .waddr_i (RAM_AW'(wr_ptr_q)),
      .wdata_i (i_push_data),
      .rd_i    (pop_ok),
      .raddr_i (RAM_AW'(rd_ptr_q)),
      .rdata_o (o_rd_data)
   );

   assign o_rd_valid = rd_valid_q;
   assign o_full     = full;
   assign o_empty    = empty;
   assign o_afull    = (count_q >= AFULL_C);
   assign o_count    = count_q;
   assign o_ovf      = ovf_q;
   assign o_udf      = udf_q;

endmodule

`default_nettype wire

// File: tb/tb_sync_fifo_ctrl.sv
// ============================================================================
// tb_sync_fifo_ctrl : directed bench for sync_fifo_ctrl with a queue model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_sync_fifo_ctrl;

   localparam int DEPTH = 16;
   localparam int WIDTH = 32;
   localparam int AFULL = 14;

   logic             clk;
   logic             rst_n;
   logic             clr;
   logic             push;
   logic [WIDTH-1:0] push_data;
   logic             pop;
   logic [WIDTH-1:0] rd_data;
   logic             rd_valid;
   logic             full;
   logic             empty;
   logic             afull;
   logic [4:0]       count;
   logic             ovf;
   logic             udf;

   int checks = 0;
   int errors = 0;

   // Reference model: stored contents, expected read data in flight, flags.
   logic [WIDTH-1:0] m_data [$];
   logic [WIDTH-1:0] exp_rd [$];
   int               m_count = 0;
   bit               m_ovf   = 0;
   bit               m_udf   = 0;
   logic [WIDTH-1:0] next_val;

   sync_fifo_ctrl #(
      .DEPTH (DEPTH),
      .WIDTH (WIDTH),
      .AFULL (AFULL)
   ) dut (
      .i_sys_clk   (clk),
      .i_rst_n     (rst_n),
      .i_clr       (clr),
      .i_push      (push),
      .i_push_data (push_data),
      .i_pop       (pop),
      .o_rd_data   (rd_data),
      .o_rd_valid  (rd_valid),
      .o_full      (full),
      .o_empty     (empty),
      .o_afull     (afull),
      .o_count     (count),
      .o_ovf       (ovf),
      .o_udf       (udf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_flags(input string tag);
      check({tag, ".count"}, 64'(count), 64'(m_count));
      check({tag, ".empty"}, 64'(empty), 64'(m_count == 0));
      check({tag, ".full"},  64'(full),  64'(m_count == DEPTH));
      check({tag, ".afull"}, 64'(afull), 64'(m_count >= AFULL));
      check({tag, ".ovf"},   64'(ovf),   64'(m_ovf));
      check({tag, ".udf"},   64'(udf),   64'(m_udf));
   endtask

   // One clock with the given requests; model updated on the drive side,
   // read data popped from the scoreboard when o_rd_valid is due.
   task automatic do_cycle(input string tag, input bit p, input logic [WIDTH-1:0] d,
                           input bit q, input bit c);
      bit push_ok;
      bit pop_ok;
      push      = p;
      push_data = d;
      pop       = q;
      clr       = c;
      push_ok   = p && !c && (m_count != DEPTH);
      pop_ok    = q && !c && (m_count != 0);
      if (c) begin
         m_data.delete();
         m_count = 0;
         m_ovf   = 0;
         m_udf   = 0;
      end else begin
         if (p && !push_ok) m_ovf = 1;
         if (q && !pop_ok)  m_udf = 1;
         if (pop_ok)  exp_rd.push_back(m_data.pop_front());
         if (push_ok) m_data.push_back(d);
         if (push_ok && !pop_ok) m_count++;
         if (pop_ok && !push_ok) m_count--;
      end
      @(posedge clk);
      #1;
      push = 1'b0;
      pop  = 1'b0;
      clr  = 1'b0;
      check_flags(tag);
      check({tag, ".rd_valid"}, 64'(rd_valid), 64'(pop_ok));
      if (pop_ok) begin
         check({tag, ".rd_data"}, 64'(rd_data), 64'(exp_rd.pop_front()));
      end
   endtask

   task automatic do_reset(input string tag, input bit hold_pop);
      @(negedge clk);
      pop   = hold_pop;
      rst_n = 1'b0;
      #1;
      m_data.delete();
      exp_rd.delete();
      m_count = 0;
      m_ovf   = 0;
      m_udf   = 0;
      check_flags(tag);
      check({tag, ".rd_valid"}, 64'(rd_valid), 64'd0);
      check({tag, ".rd_data"},  64'(rd_data),  64'd0);
      @(negedge clk);
      @(negedge clk);
      pop   = 1'b0;
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n     = 1'b1;
      clr       = 1'b0;
      push      = 1'b0;
      push_data = '0;
      pop       = 1'b0;

      // Reset asserted away from any clock edge; outputs must react at once.
      #3;
      rst_n = 1'b0;
      #1;
      check_flags("reset");
      check("reset.rd_valid", 64'(rd_valid), 64'd0);
      check("reset.rd_data",  64'(rd_data),  64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Fill to full, then one rejected push.
      for (int i = 0; i < DEPTH; i++) begin
         do_cycle("fill", 1'b1, 32'(i), 1'b0, 1'b0);
      end
      do_cycle("fill_ovf", 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0);

      // Drain in order, then one rejected pop.
      for (int i = 0; i < DEPTH; i++) begin
         do_cycle("drain", 1'b0, '0, 1'b1, 1'b0);
      end
      do_cycle("drain_udf", 1'b0, '0, 1'b1, 1'b0);

      // Overlapped push/pop rounds so both pointers wrap several times.
      next_val = 32'h0000_1000;
      for (int r = 0; r < 5; r++) begin
         for (int k = 0; k <= 10; k++) begin
            do_cycle("wrap", k < 10, next_val, k > 0, 1'b0);
            if (k < 10) next_val = next_val + 1;
         end
      end

      // Flush to a known state, then the simultaneous-request edge cases.
      do_cycle("clr0", 1'b0, '0, 1'b0, 1'b1);
      do_cycle("edge_empty", 1'b1, 32'hA5A5_0000, 1'b1, 1'b0);
      for (int i = 1; i < DEPTH; i++) begin
         do_cycle("edge_fill", 1'b1, 32'hA5A5_0000 + 32'(i), 1'b0, 1'b0);
      end
      do_cycle("edge_full", 1'b1, 32'h5A5A_FFFF, 1'b1, 1'b0);
      for (int i = 0; i < 10; i++) begin
         do_cycle("edge_pop", 1'b0, '0, 1'b1, 1'b0);
      end

      // Five entries held: flush with a concurrent pop.
      do_cycle("clr_pop", 1'b0, '0, 1'b1, 1'b1);
      do_cycle("clr_after", 1'b0, '0, 1'b0, 1'b0);

      // Rebuild five entries with udf set, then reset mid-stream with a pop held.
      do_cycle("pre_rst_udf", 1'b0, '0, 1'b1, 1'b0);
      for (int i = 0; i < 5; i++) begin
         do_cycle("pre_rst_fill", 1'b1, 32'hC0DE_0000 + 32'(i), 1'b0, 1'b0);
      end
      do_reset("rst_mid", 1'b1);
      do_cycle("rst_after", 1'b0, '0, 1'b0, 1'b0);

      // Still functional after the mid-stream reset.
      do_cycle("post_push", 1'b1, 32'h1234_5678, 1'b0, 1'b0);
      do_cycle("post_pop",  1'b0, '0, 1'b1, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
